// File: rtl/regbank_32_wr.sv
// rtl/regbank_32_wr.sv - write side of the 32x32 register bank with clear-sweep sequencer
// Optional build macro: ZERO_REG_EN (register 0 hardwired to zero, sweep covers 1..31).
module regbank_32_wr (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [4:0]    wr_sel,
  input  logic [31:0]   wr_data,
  input  logic          clr_req,
  output logic          busy,
  output logic          wr_ack,
  output logic [1023:0] q
);

`ifdef ZERO_REG_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_next;
  logic [4:0] ptr, ptr_next;
  logic       accept, sweep;
  logic [31:FIRST] wen, clr_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The pointer parks at 31 after the last clear instead of wrapping.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = 5'(FIRST);
        end
      end
      CLEAR: begin
        if (ptr == 5'd31) begin
          state_next = IDLE;
        end else begin
          ptr_next = ptr + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == CLEAR);
    sweep  = (state == CLEAR);
    accept = (state == IDLE) && we && !clr_req;
  end

  always_comb begin
    wen     = '0;
    clr_hit = '0;
    for (int k = FIRST; k < 32; k++) begin
      wen[k]     = accept && (wr_sel == 5'(k));
      clr_hit[k] = sweep && (ptr == 5'(k));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= accept;
    end
  end

  // A write to a hardwired index is still acknowledged via accept; only storage is absent.
  for (genvar k = 0; k < 32; k++) begin : g_reg
    if (k < FIRST) begin : g_zero
      assign q[32*k +: 32] = '0;
    end else begin : g_store
      logic [31:0] r;
      always_ff @(posedge clock) begin
        if (reset) begin
          r <= '0;
        end else if (clr_hit[k]) begin
          r <= '0;
        end else if (wen[k]) begin
          r <= wr_data;
        end
      end
      assign q[32*k +: 32] = r;
    end
  end

endmodule

// File: tb/tb_regbank_32_wr.sv
// tb/tb_regbank_32_wr.sv - self-checking bench for regbank_32_wr against a behavioural bank model
module tb_regbank_32_wr;

`ifdef ZERO_REG_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NCLR = 32 - FIRST;

  logic          clock = 1'b0;
  logic          reset;
  logic          we;
  logic [4:0]    wr_sel;
  logic [31:0]   wr_data;
  logic          clr_req;
  logic          busy;
  logic          wr_ack;
  logic [1023:0] q;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  regbank_32_wr dut (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .busy    (busy),
    .wr_ack  (wr_ack),
    .q       (q)
  );

  always #5 clock = ~clock;

  // Model: an array of register values plus a count of sweep cycles still owed.
  logic [31:0] m_reg [32];
  int          m_left = 0;
  int          m_idx  = 0;
  bit          m_ack  = 0;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_left = 0;
      m_ack  = 0;
    end else if (m_left > 0) begin
      m_reg[m_idx] = '0;
      m_idx  = m_idx + 1;
      m_left = m_left - 1;
      m_ack  = 0;
    end else if (clr_req) begin
      m_left = NCLR;
      m_idx  = FIRST;
      m_ack  = 0;
    end else if (we) begin
      if (int'(wr_sel) >= FIRST) m_reg[wr_sel] = wr_data;
      m_ack = 1;
    end else begin
      m_ack = 0;
    end
  end

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1023:0] model_q();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = m_reg[i];
    return v;
  endfunction

  always @(negedge clock) begin
    if (check_en) begin
      check("cyc_q", q, model_q());
      check("cyc_busy", 1024'(busy), 1024'(m_left > 0));
      check("cyc_ack", 1024'(wr_ack), 1024'(m_ack));
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  logic [1023:0] snap;
  int n;

  initial begin
    reset = 1; we = 0; wr_sel = '0; wr_data = '0; clr_req = 0;
    cyc(); cyc();
    check("rst_q", q, '0);
    check("rst_busy", 1024'(busy), 1024'(0));
    check("rst_ack", 1024'(wr_ack), 1024'(0));
    reset = 0;
    check_en = 1;

    // write-all on consecutive cycles
    n = 0;
    for (int k = 0; k < 32; k++) begin
      we = 1; wr_sel = 5'(k); wr_data = 32'(k + 100);
      cyc();
      if (wr_ack) n++;
    end
    we = 0;
    check("wall_acks", 1024'(n), 1024'(32));
    check("wall_s1", 1024'(q[32*1 +: 32]), 1024'(101));
    check("wall_s17", 1024'(q[32*17 +: 32]), 1024'(117));
    check("wall_s31", 1024'(q[32*31 +: 32]), 1024'(131));
    check("wall_s0", 1024'(q[31:0]), 1024'((FIRST == 1) ? 0 : 100));
    cyc();
    check("wall_ack_drop", 1024'(wr_ack), 1024'(0));

    // isolation
    snap = q;
    snap[32*17 +: 32] = 32'hDEADBEEF;
    we = 1; wr_sel = 5'd17; wr_data = 32'hDEADBEEF;
    cyc();
    we = 0;
    check("iso_q", q, snap);

    // clear sweep
    clr_req = 1;
    cyc();
    clr_req = 0;
    n = 0;
    while (busy && n < 100) begin
      if (n == 3) check("sweep_mid_s31", 1024'(q[32*31 +: 32]), 1024'(131));
      n++;
      cyc();
    end
    check("sweep_len", 1024'(n), 1024'(NCLR));
    check("sweep_q_zero", q, '0);

    // collision: clear wins over simultaneous write
    we = 1; wr_sel = 5'd5; wr_data = 32'h1234;
    cyc();
    we = 1; wr_sel = 5'd5; wr_data = 32'h55; clr_req = 1;
    cyc();
    clr_req = 0;
    check("coll_ack", 1024'(wr_ack), 1024'(0));
    check("coll_s5", 1024'(q[32*5 +: 32]), 1024'(32'h1234));
    n = 0;
    while (busy && n < 100) begin
      we = n[0]; wr_sel = 5'd9; wr_data = 32'h77;
      n++;
      cyc();
      check("coll_busy_ack", 1024'(wr_ack), 1024'(0));
    end
    we = 0;
    check("coll_len", 1024'(n), 1024'(NCLR));
    check("coll_q_zero", q, '0);

    // reset mid-sweep
    we = 1; wr_sel = 5'd20; wr_data = 32'hABC;
    cyc();
    we = 0; clr_req = 1;
    cyc();
    clr_req = 0;
    for (int i = 0; i < 10; i++) cyc();
    check("mid_busy", 1024'(busy), 1024'(1));
    reset = 1;
    cyc();
    reset = 0;
    check("mrst_busy", 1024'(busy), 1024'(0));
    check("mrst_q", q, '0);
    we = 1; wr_sel = 5'd3; wr_data = 32'd7;
    cyc();
    we = 0;
    check("mrst_s3", 1024'(q[32*3 +: 32]), 1024'(7));
    check("mrst_ack", 1024'(wr_ack), 1024'(1));
    cyc();
    check("mrst_ack_end", 1024'(wr_ack), 1024'(0));

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regbank_32_wr.md
# regbank_32_wr

Write side of the 32-entry, 32-bit register bank whose read side is the existing 32:1 read multiplexer. It decodes a 5-bit write select into per-register write enables, holds all 32 registers, and exposes them as one flattened bus that feeds the read mux directly. A small sequencer clears the whole bank on request, one register per cycle, with a busy flag and a write acknowledge.

## Interface
Parameters:
- none; data width is fixed at 32 and depth at 32.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  write request, sampled on each rising edge.
- `wr_sel`  in  5  target register index, 0–31.
- `wr_data`  in  32  write data.
- `clr_req`  in  1  starts a bank-clear sweep; sampled only in IDLE.
- `busy`  out  1  high while a clear sweep is in progress.
- `wr_ack`  out  1  one-cycle pulse, registered; high in the cycle after an accepted write.
- `q`  out  1024  flattened registers; `q[32*k+31:32*k]` is register k.

## Operation
- Sequencer states:
  - IDLE: accepts writes and clear requests.
  - CLEAR: runs the sweep using a 5-bit pointer `ptr`.
- IDLE, `clr_req`=1:
  - Enter CLEAR and load `ptr` with the first clearable index (1 with `ZERO_REG_EN`, 0 without).
  - Any simultaneous `we` is dropped, with no `wr_ack`. Clear has priority.
- IDLE, `we`=1, `clr_req`=0: the write is accepted.
  - Register `wr_sel` takes `wr_data`.
  - `wr_ack` is high in the next cycle.
- CLEAR:
  - Each cycle, register `ptr` is set to 0 and `ptr` increments.
  - When `ptr`=31 is cleared, return to IDLE.
  - `ptr` never wraps.
- In CLEAR, `we` and `clr_req` are ignored: no register update and no `wr_ack`. A write in flight is not queued.
- Decoder: exactly one register is enabled per accepted write; all others hold.
- Reset value of every output:
  - `q` = all zeros.
  - `busy` = 0.
  - `wr_ack` = 0.
  - State = IDLE and `ptr` = 0.
- Reset during CLEAR aborts the sweep. All registers are zero after the reset edge regardless of sweep progress.
- Writes carrying X on `wr_sel` while `we`=1 are a bench error; no defined behaviour.

## Timing
- Write latency: data on `q` is visible in the cycle after the accepting edge. `wr_ack` is high in that same cycle, for exactly one cycle.
- Back-to-back writes are accepted every cycle. `wr_ack` stays high continuously for consecutive accepted writes.
- `busy` rises in the cycle after the edge that samples `clr_req` in IDLE.
  - With `ZERO_REG_EN`: `busy` is high for exactly 31 cycles.
  - Without `ZERO_REG_EN`: `busy` is high for exactly 32 cycles.
- The first write after a sweep is accepted at the first edge where `busy`=0.
- `q` is purely registered. There is no combinational path from any input to `q`, `busy` or `wr_ack`.

## Configuration
- `ZERO_REG_EN` defined:
  - Register 0 is hardwired to zero.
  - Writes to index 0 are accepted and acknowledged (`wr_ack` pulses) but discarded.
  - The sweep covers 1..31 (31 cycles).
- `ZERO_REG_EN` undefined:
  - Register 0 is an ordinary writable register.
  - The sweep covers 0..31 (32 cycles).

## Test plan
- Write-all: after reset, write k+100 to each index k=0..31 on consecutive cycles.
  - `wr_ack` is high for 32 consecutive cycles.
  - `q` slice k = k+100 for k≥1.
  - Slice 0 = 0 with `ZERO_REG_EN`, 100 without.
- Isolation: write 0xDEADBEEF to index 17.
  - Only slice 17 changes.
  - Other 31 slices are unchanged, bit-exact.
- Clear sweep: fill the bank, pulse `clr_req` for 1 cycle.
  - `busy` is high 31 cycles (`ZERO_REG_EN`) or 32 cycles (undefined).
  - Registers clear in ascending index order, one per cycle.
  - All of `q` = 0 when `busy` falls.
- Collision:
  - `we`=1 with `wr_sel`=5, `wr_data`=0x55 in the same cycle as `clr_req`=1 → slice 5 is not written and `wr_ack` stays 0.
  - `we` pulses during `busy` → ignored and no `wr_ack`.
- Reset mid-sweep: assert `reset` at sweep cycle 10.
  - The next cycle shows `busy`=0, `q`=0 and IDLE.
  - A write to index 3 with value 7 on the following edge gives slice 3 = 7 and a `wr_ack` pulse.
